// File: rtl/wb_select_pipe_if.sv
// Handshake bundle for wb_select_pipe.
// Producer side: data_in, sel, in_valid/in_ready. Consumer side: out_data, out_valid/out_ready.
// Error side: sel_err, err_clr, err_count.
// master = the environment that drives sources and consumes results; slave = the selector.
interface wb_select_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 9,
  parameter int SEL_W = 4
);
  logic [N_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
  logic                  err_clr;
  logic [15:0]           err_count;

  modport master (
    output data_in, sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_valid, sel_err, err_count
  );

  modport slave (
    input  data_in, sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_valid, sel_err, err_count
  );
endinterface

// File: rtl/wb_select_pipe.sv
// Purpose: N-way write-back source selector with a 2-entry elastic (skid) output stage.
// Latency: 1 cycle from accept to out_valid; 1 word/cycle with out_ready held high.
// Backpressure: in_ready drops only when both entries are full; it decodes state alone.
//
// Ports: clk, reset (async active-low), bus (wb_select_pipe_if.slave):
//   data_in/sel/in_valid/in_ready  - producer handshake, source k = data_in[k*WIDTH +: WIDTH]
//   out_data/out_valid/out_ready   - registered result handshake
//   sel_err/err_clr/err_count      - sticky illegal-select flag, clear, optional counter
// Optional feature macro: WB_SEL_ERR_COUNT_EN (16-bit saturating illegal-select counter;
// when undefined err_count is tied to zero and no counter flops exist).
module wb_select_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 9,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_select_pipe_if.slave  bus
);

  if (N_IN < 2 || (2**SEL_W) < N_IN) begin : g_bad_params
    $error("wb_select_pipe: need N_IN >= 2 and 2**SEL_W >= N_IN");
  end

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_q, s_q, sel_word;
  logic             accept, illegal, bad_accept;
  logic             load_m, load_s, m_from_s;
  logic             err_q;

  // Unmatched (out-of-range) selects fall through to the all-zero default.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (bus.sel == SEL_W'(k)) sel_word = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  assign illegal    = int'(bus.sel) >= N_IN;
  assign accept     = bus.in_valid & bus.in_ready;
  assign bad_accept = accept & illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_m    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && !bus.out_ready) begin
          load_s    = 1'b1;
          state_nxt = TWO;
        end else if (accept) begin
          load_m    = 1'b1;
        end else if (bus.out_ready) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (bus.out_ready) begin
          m_from_s  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m)        m_q <= sel_word;
      else if (m_from_s) m_q <= s_q;
      if (load_s)        s_q <= sel_word;
    end
  end

  // A new illegal accept takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          err_q <= 1'b0;
    else if (bad_accept) err_q <= 1'b1;
    else if (bus.err_clr) err_q <= 1'b0;
  end

`ifdef WB_SEL_ERR_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              cnt_q <= 16'h0000;
    else if (bus.err_clr)                    cnt_q <= bad_accept ? 16'h0001 : 16'h0000;
    else if (bad_accept && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h0001;
  end

  assign bus.err_count = cnt_q;
`else
  assign bus.err_count = 16'h0000;
`endif

  assign bus.out_data  = m_q;
  assign bus.out_valid = (state != EMPTY);
  assign bus.in_ready  = (state != TWO);
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Bench for wb_select_pipe: directed phases on a 32x9 instance, randomized scoreboard on an
// 8x3 instance. Expected words are queued at accept time and popped by output monitors.
module tb_wb_select_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_select_pipe_if #(.WIDTH(32), .N_IN(9), .SEL_W(4)) bus_a ();
  wb_select_pipe_if #(.WIDTH(8),  .N_IN(3), .SEL_W(2)) bus_b ();

  wb_select_pipe #(.WIDTH(32), .N_IN(9), .SEL_W(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  wb_select_pipe #(.WIDTH(8),  .N_IN(3), .SEL_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] q_a[$];
  logic [7:0]  q_b[$];
  bit          exp_err_a = 1'b0, exp_err_b = 1'b0;
  int          exp_cnt_a = 0;
  logic [7:0]  srcb [3];

  function automatic logic [31:0] cnt_req(input int n);
`ifdef WB_SEL_ERR_COUNT_EN
    return (n > 65535) ? 32'hFFFF : 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Input observer A: checks error outputs against the model, then records this cycle's accept.
  always @(negedge clk) begin : obs_a
    bit acc, bad;
    if (!reset) begin
      exp_err_a = 1'b0;
      exp_cnt_a = 0;
    end else begin
      chk("sel_err_a", bus_a.sel_err, exp_err_a);
      chk("err_count_a", bus_a.err_count, cnt_req(exp_cnt_a));
      acc = bus_a.in_valid && bus_a.in_ready;
      bad = acc && (bus_a.sel >= 9);
      if (acc) q_a.push_back(bad ? 32'h0 : 32'hA000_0000 + 32'(bus_a.sel));
      if (bus_a.err_clr) begin
        exp_err_a = bad;
        exp_cnt_a = bad ? 1 : 0;
      end else if (bad) begin
        exp_err_a = 1'b1;
        if (exp_cnt_a < 65535) exp_cnt_a++;
      end
    end
  end

  // Output monitor A: pops on every transfer, and checks holding while stalled.
  bit          stall_a = 1'b0;
  logic [31:0] held_a;
  always @(negedge clk) begin : mon_a
    if (!reset) stall_a = 1'b0;
    else begin
      if (stall_a) begin
        chk("hold_vld_a", bus_a.out_valid, 1'b1);
        chk("hold_dat_a", bus_a.out_data, held_a);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a unexpected word %h, none expected", bus_a.out_data);
        end else begin
          logic [31:0] e;
          e = q_a.pop_front();
          if (bus_a.out_data !== e) begin
            errors++;
            $display("FAIL sb_a got %h want %h", bus_a.out_data, e);
          end
        end
      end
      stall_a = bus_a.out_valid && !bus_a.out_ready;
      held_a  = bus_a.out_data;
    end
  end

  always @(negedge clk) begin : obs_b
    bit acc, bad;
    if (!reset) exp_err_b = 1'b0;
    else begin
      chk("sel_err_b", bus_b.sel_err, exp_err_b);
      acc = bus_b.in_valid && bus_b.in_ready;
      bad = acc && (bus_b.sel == 2'd3);
      if (acc) q_b.push_back(bad ? 8'h00 : srcb[bus_b.sel]);
      if (bad) exp_err_b = 1'b1;
      else if (bus_b.err_clr) exp_err_b = 1'b0;
    end
  end

  bit         stall_b = 1'b0;
  logic [7:0] held_b;
  always @(negedge clk) begin : mon_b
    if (!reset) stall_b = 1'b0;
    else begin
      if (stall_b) begin
        chk("hold_vld_b", bus_b.out_valid, 1'b1);
        chk("hold_dat_b", bus_b.out_data, held_b);
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b unexpected word %h, none expected", bus_b.out_data);
        end else begin
          logic [7:0] e;
          e = q_b.pop_front();
          if (bus_b.out_data !== e) begin
            errors++;
            $display("FAIL sb_b got %h want %h", bus_b.out_data, e);
          end
        end
      end
      stall_b = bus_b.out_valid && !bus_b.out_ready;
      held_b  = bus_b.out_data;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b0;
    for (int k = 0; k < 9; k++) bus_a.data_in[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    bus_a.sel = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1; bus_a.err_clr = 1'b0;
    for (int k = 0; k < 3; k++) srcb[k] = 8'h00;
    bus_b.data_in = '0; bus_b.sel = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    bus_b.err_clr = 1'b0;
    #1;
    chk("rst_vld", bus_a.out_valid, 1'b0);
    chk("rst_dat", bus_a.out_data, 32'h0);
    chk("rst_rdy", bus_a.in_ready, 1'b1);
    chk("rst_err", bus_a.sel_err, 1'b0);
    chk("rst_cnt", bus_a.err_count, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Streaming: one word per cycle, each visible the cycle after its accept.
    for (int k = 0; k < 9; k++) begin
      bus_a.sel = 4'(k); bus_a.in_valid = 1'b1;
      step();
      chk("t1_vld", bus_a.out_valid, 1'b1);
      chk("t1_dat", bus_a.out_data, 32'hA000_0000 + 32'(k));
      chk("t1_rdy", bus_a.in_ready, 1'b1);
    end
    bus_a.in_valid = 1'b0;
    step();
    chk("t1_idle", bus_a.out_valid, 1'b0);

    // Back-pressure: two words buffered, third waits for space.
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.sel = 4'd1;
    step();
    chk("t2_rdy1", bus_a.in_ready, 1'b1);
    chk("t2_dat1", bus_a.out_data, 32'hA000_0001);
    bus_a.sel = 4'd2;
    step();
    chk("t2_full", bus_a.in_ready, 1'b0);
    bus_a.sel = 4'd3;
    step();
    chk("t2_full2", bus_a.in_ready, 1'b0);
    chk("t2_hold", bus_a.out_data, 32'hA000_0001);
    bus_a.out_ready = 1'b1;
    step();
    chk("t2_dat2", bus_a.out_data, 32'hA000_0002);
    chk("t2_rdy2", bus_a.in_ready, 1'b1);
    step();
    chk("t2_dat3", bus_a.out_data, 32'hA000_0003);
    bus_a.in_valid = 1'b0;
    step();
    chk("t2_idle", bus_a.out_valid, 1'b0);

    // Illegal selects, clear priority, and un-accepted illegal selects.
    bus_a.sel = 4'hC; bus_a.in_valid = 1'b1;
    step();
    chk("t3_zero", bus_a.out_data, 32'h0);
    chk("t3_err", bus_a.sel_err, 1'b1);
    bus_a.sel = 4'hF; bus_a.err_clr = 1'b1;
    step();
    chk("t3_set_wins", bus_a.sel_err, 1'b1);
    chk("t3_zero2", bus_a.out_data, 32'h0);
    bus_a.in_valid = 1'b0;
    step();
    chk("t3_clr", bus_a.sel_err, 1'b0);
    bus_a.err_clr = 1'b0;
    step();
    chk("t3_noacc", bus_a.sel_err, 1'b0);
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.sel = 4'd0;
    step();
    bus_a.sel = 4'd1;
    step();
    bus_a.sel = 4'hF;
    step();
    chk("t3_full", bus_a.in_ready, 1'b0);
    chk("t3_noacc_full", bus_a.sel_err, 1'b0);
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    repeat (3) step();
    chk("t3_drain", bus_a.out_valid, 1'b0);

    // Illegal-select counter.
    bus_a.err_clr = 1'b1;
    step();
    bus_a.err_clr = 1'b0; bus_a.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_a.sel = 4'(9 + i);
      step();
    end
    bus_a.in_valid = 1'b0;
    step();
    chk("t5_cnt5", bus_a.err_count, cnt_req(5));
`ifdef WB_SEL_ERR_COUNT_EN
    bus_a.in_valid = 1'b1; bus_a.sel = 4'hF;
    repeat (65535) step();
`else
    bus_a.in_valid = 1'b1; bus_a.sel = 4'hF;
    repeat (20) step();
`endif
    bus_a.in_valid = 1'b0;
    step();
    chk("t5_sat", bus_a.err_count, cnt_req(65540));

    // Asynchronous reset while both entries are full.
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.sel = 4'd5;
    step();
    bus_a.sel = 4'd6;
    step();
    chk("t4_full", bus_a.in_ready, 1'b0);
    bus_a.in_valid = 1'b0;
    #2 reset = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk("t4_vld", bus_a.out_valid, 1'b0);
    chk("t4_dat", bus_a.out_data, 32'h0);
    chk("t4_rdy", bus_a.in_ready, 1'b1);
    chk("t4_err", bus_a.sel_err, 1'b0);
    chk("t4_cnt", bus_a.err_count, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    bus_a.out_ready = 1'b1;
    repeat (3) step();
    chk("t4_no_old", bus_a.out_valid, 1'b0);

    // Random traffic on the 8-bit, 3-source instance.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) srcb[k] = 8'($urandom);
      bus_b.data_in   = {srcb[2], srcb[1], srcb[0]};
      bus_b.sel       = 2'($urandom_range(0, 3));
      bus_b.in_valid  = ($urandom_range(0, 3) != 0);
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      bus_b.err_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.err_clr = 1'b0;
    repeat (4) step();
    chk("drain_b", 32'(q_b.size()), 32'h0);
    chk("drain_a", 32'(q_a.size()), 32'h0);
    chk("idle_b", bus_b.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
